// File: rtl/wb_ram_pkg.sv
// Shared constants and FSM encoding for the Wishbone RAM responder.
package wb_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam int unsigned WB_DW         = 32;
    localparam int unsigned WB_SW         = 4;
    localparam int unsigned DEF_DELAY     = 4;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h3800_0000;

endpackage

// File: rtl/wb_ram_bank.sv
// Single-port synchronous RAM with per-byte write enables; read data registered.
module wb_ram_bank
    import wb_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [WB_SW-1:0]      sel,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WB_DW-1:0]      wdata,
    output logic [WB_DW-1:0]      rdata
);

    logic [WB_DW-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    // Byte-lane write or registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < WB_SW; b++) begin
                    if (sel[b]) r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata <= r_mem[addr];
            end
        end
    end

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone classic slave in front of the user RAM: latch request, wait DELAY
// cycles, access the bank, return a one-cycle ack. Outputs are zero outside
// the ACCESS state so they can be OR-ed onto the arbiter's return path.
module wb_ram_responder
    import wb_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DELAY      = DEF_DELAY,
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [WB_SW-1:0] wbs_sel_i,
    input  logic [WB_DW-1:0] wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [WB_DW-1:0] wbs_dat_o
);

    localparam logic [3:0] LP_DELAY = 4'(DELAY);

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic                  r_we;
    logic [WB_SW-1:0]      r_sel;
    logic [WB_DW-1:0]      r_dat;
    logic                  r_in_range;

    logic                  w_valid;
    logic                  w_in_range;
    logic                  w_bank_en;
    logic [WB_DW-1:0]      w_bank_rdata;
    logic                  w_unused;

    assign w_valid    = wbs_stb_i & wbs_cyc_i;
    assign w_in_range = (wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    // Byte offset within a word carries no meaning for 32-bit transfers.
    assign w_unused   = ^wbs_adr_i[1:0];

    // Next-state decode; the bank is strobed on the WAIT->ACCESS edge only.
    always_comb begin
        w_state_nxt = r_state;
        w_bank_en   = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_valid) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (!w_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == LP_DELAY) begin
                    w_state_nxt = ST_ACCESS;
                    w_bank_en   = r_in_range;
                end
            end
            ST_ACCESS: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Request latches captured on acceptance; wait counter advances in WAIT.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_cnt      <= '0;
            r_adr      <= '0;
            r_we       <= 1'b0;
            r_sel      <= '0;
            r_dat      <= '0;
            r_in_range <= 1'b0;
        end else if (r_state == ST_IDLE && w_valid) begin
            r_cnt      <= 4'd1;
            r_adr      <= wbs_adr_i[ADDR_WIDTH+1:2];
            r_we       <= wbs_we_i;
            r_sel      <= wbs_sel_i;
            r_dat      <= wbs_dat_i;
            r_in_range <= w_in_range;
        end else if (r_state == ST_WAIT && w_valid && r_cnt != LP_DELAY) begin
            r_cnt      <= r_cnt + 4'd1;
        end
    end

    wb_ram_bank #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
        .clk   (wb_clk_i),
        .en    (w_bank_en),
        .we    (r_we),
        .sel   (r_sel),
        .addr  (r_adr),
        .wdata (r_dat),
        .rdata (w_bank_rdata)
    );

    assign wbs_ack_o = (r_state == ST_ACCESS) & w_valid;
    assign wbs_dat_o = (r_state == ST_ACCESS && !r_we && r_in_range) ? w_bank_rdata : '0;

endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed bench for wb_ram_responder (DELAY=4): vector table plus corner sequences.
module tb_wb_ram_responder;

    localparam int LAT = 5;   // DELAY + 1

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] exp_dat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr;
    logic        ack;
    logic [31:0] dat_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] rd_dat;
    logic        idle_bad;
    vec_t        vecs [16];

    wb_ram_responder dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (dat_i),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called #1 after a posedge (cycle k=0); returns cycles to ack, -1 on timeout.
    task automatic wait_ack(output int lat);
        lat      = -1;
        idle_bad = 1'b0;
        rd_dat   = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ack) begin
                lat    = k;
                rd_dat = dat_o;
                break;
            end
            if (dat_o != 0) idle_bad = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        we = v.we; sel = v.sel; adr = v.adr; dat_i = v.dat;
        stb = 1'b1; cyc = 1'b1;
        wait_ack(lat);
        check({nm, "_lat"}, 32'(lat), 32'(LAT));
        check({nm, "_dat"}, rd_dat, v.exp_dat);
        check({nm, "_idle_dat"}, 32'(idle_bad), 32'd0);
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        check({nm, "_ack_1cyc"}, 32'(ack), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat, lat2;
        logic seen;
        vec_t v;

        vecs[0]  = '{1'b1, 4'hF, 32'h3800_0010, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 4'hF, 32'h3800_0010, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b1, 4'hF, 32'h3800_0020, 32'h11223344, 32'h0};
        vecs[3]  = '{1'b1, 4'h2, 32'h3800_0020, 32'h0000AB00, 32'h0};
        vecs[4]  = '{1'b0, 4'hF, 32'h3800_0020, 32'h0,        32'h1122AB44};
        vecs[5]  = '{1'b1, 4'hF, 32'h3800_0030, 32'hCAFEF00D, 32'h0};
        vecs[6]  = '{1'b1, 4'h0, 32'h3800_0030, 32'hFFFFFFFF, 32'h0};
        vecs[7]  = '{1'b0, 4'hF, 32'h3800_0030, 32'h0,        32'hCAFEF00D};
        vecs[8]  = '{1'b1, 4'hF, 32'h3800_000C, 32'h0BADC0DE, 32'h0};
        vecs[9]  = '{1'b1, 4'hF, 32'h3900_0010, 32'h12345678, 32'h0};
        vecs[10] = '{1'b0, 4'hF, 32'h3800_0010, 32'h0,        32'hDEADBEEF};
        vecs[11] = '{1'b0, 4'hF, 32'h3900_0010, 32'h0,        32'h0};
        vecs[12] = '{1'b0, 4'hF, 32'h3800_0013, 32'h0,        32'hDEADBEEF};
        vecs[13] = '{1'b1, 4'h9, 32'h3800_0020, 32'h99000077, 32'h0};
        vecs[14] = '{1'b0, 4'hF, 32'h3800_0020, 32'h0,        32'h9922AB77};
        vecs[15] = '{1'b0, 4'hF, 32'h37FF_FFFC, 32'h0,        32'h0};

        // Reset held with a request pending: outputs stay quiet, ack DELAY+1 after release.
        rst = 1'b1; stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF;
        dat_i = '0; adr = 32'h3900_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_ack", 32'(ack), 32'd0);
            check("rst_dat", dat_o, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ack(lat);
        check("rst_rel_lat", 32'(lat), 32'(LAT));
        check("rst_rel_dat", rd_dat, 32'd0);
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        check("rst_rel_ack_1cyc", 32'(ack), 32'd0);
        @(posedge clk); #1;

        // Table of single transfers.
        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort: stb dropped in the 2nd WAIT cycle of a write to word 3.
        we = 1'b1; sel = 4'hF; adr = 32'h3800_000C; dat_i = 32'h0000_0055;
        stb = 1'b1; cyc = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        check("abort_no_ack", 32'(seen), 32'd0);
        @(posedge clk); #1;
        v = '{1'b0, 4'hF, 32'h3800_000C, 32'h0, 32'h0BADC0DE};
        run_vec(v, "abort_readback");

        // Back-to-back reads with stb held, address changed on ack.
        we = 1'b0; sel = 4'hF; adr = 32'h3800_0010; stb = 1'b1; cyc = 1'b1;
        wait_ack(lat);
        check("b2b_lat1", 32'(lat), 32'(LAT));
        check("b2b_dat1", rd_dat, 32'hDEADBEEF);
        @(posedge clk); #1;
        adr = 32'h3800_0020;
        wait_ack(lat2);
        check("b2b_gap", 32'(lat2 + 1), 32'(LAT + 1));
        check("b2b_dat2", rd_dat, 32'h9922AB77);
        // Third transfer is a write, killed by reset mid-WAIT.
        @(posedge clk); #1;
        we = 1'b1; adr = 32'h3800_0010; dat_i = 32'h1111_1111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; stb = 1'b0; cyc = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        check("b2b_rst_no_ack", 32'(seen), 32'd0);
        @(posedge clk); #1;
        v = '{1'b0, 4'hF, 32'h3800_0010, 32'h0, 32'hDEADBEEF};
        run_vec(v, "b2b_rst_readback");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
